// File: rtl/quadc_bringup_ctrl.sv
// Bring-up and supervision sequencer for the quad-ADC capture interface (DCM reset, lock, settle, FIFO reset, run).
// Optional RUN stall watchdog is built when QUADC_CTRL_STALL_DETECT_EN is defined.
module quadc_bringup_ctrl #(
    parameter int DCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int IF_RST_CYCLES  = 8,
    parameter int VALID_TIMEOUT  = 256,
    parameter int STALL_CYCLES   = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       user_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       dcm_locked,
    input  logic       adc_valid,
    input  logic       clear_error,
    output logic       dcm_reset,
    output logic       if_reset,
    output logic       ready,
    output logic       error,
    output logic [3:0] retry_count,
    output logic [2:0] state
);
    localparam int CW = 24;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DCM_RST    = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_IF_RST     = 3'd4,
        ST_WAIT_VALID = 3'd5,
        ST_RUN        = 3'd6,
        ST_FAIL       = 3'd7
    } state_t;

    state_t        state_q, state_d, norm_next_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d, retry_inc_s;
    logic [1:0]    rst_sync_q;
    logic [1:0]    lock_sync_q;
    logic          rst_int_n, lock_s, expired_s, retry_hit_s, abort_s;
    logic          dcm_reset_q, if_reset_q, ready_q, error_q;

`ifdef QUADC_CTRL_STALL_DETECT_EN
    localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    logic [SW-1:0] stall_q, stall_d;
`endif

    // Per-state dwell: loading N-1 and leaving when the counter reads zero gives exactly N cycles.
    function automatic logic [CW-1:0] load_value(input state_t s);
        case (s)
            ST_DCM_RST:    return CW'(DCM_RST_CYCLES - 1);
            ST_WAIT_LOCK:  return CW'(LOCK_TIMEOUT - 1);
            ST_SETTLE:     return CW'(SETTLE_CYCLES - 1);
            ST_IF_RST:     return CW'(IF_RST_CYCLES - 1);
            ST_WAIT_VALID: return CW'(VALID_TIMEOUT - 1);
            default:       return {CW{1'b0}};
        endcase
    endfunction

    assign rst_int_n   = rst_sync_q[1];
    assign lock_s      = lock_sync_q[1];
    assign expired_s   = (cnt_q == {CW{1'b0}});
    assign retry_inc_s = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
    assign abort_s     = (state_q != ST_FAIL) && !enable;

    // Reset bridge: asserts asynchronously, releases two edges after reset_n rises.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Two-flop resynchronizer for the DCM lock coming from the ADC clock domain.
    always_ff @(posedge user_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], dcm_locked};
        end
    end

    // Per-state transition rules, ignoring enable abort; a failed attempt raises retry_hit_s.
    always_comb begin
        norm_next_s = state_q;
        retry_hit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) norm_next_s = ST_DCM_RST;
                else        norm_next_s = ST_IDLE;
            end
            ST_DCM_RST: begin
                if (expired_s) norm_next_s = ST_WAIT_LOCK;
                else           norm_next_s = ST_DCM_RST;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)         norm_next_s = ST_SETTLE;
                else if (expired_s) retry_hit_s = 1'b1;
                else                norm_next_s = ST_WAIT_LOCK;
            end
            ST_SETTLE: begin
                // Lock loss beats a coincident dwell expiry.
                if (!lock_s)        retry_hit_s = 1'b1;
                else if (expired_s) norm_next_s = ST_IF_RST;
                else                norm_next_s = ST_SETTLE;
            end
            ST_IF_RST: begin
                if (expired_s) norm_next_s = ST_WAIT_VALID;
                else           norm_next_s = ST_IF_RST;
            end
            ST_WAIT_VALID: begin
                if (adc_valid)      norm_next_s = ST_RUN;
                else if (expired_s) retry_hit_s = 1'b1;
                else                norm_next_s = ST_WAIT_VALID;
            end
            ST_RUN: begin
                if (!lock_s) retry_hit_s = 1'b1;
`ifdef QUADC_CTRL_STALL_DETECT_EN
                else if (!adc_valid && (stall_q == SW'(STALL_CYCLES - 1))) retry_hit_s = 1'b1;
`endif
                else norm_next_s = ST_RUN;
            end
            ST_FAIL: begin
                if (clear_error) norm_next_s = ST_IDLE;
                else             norm_next_s = ST_FAIL;
            end
            default: norm_next_s = ST_IDLE;
        endcase
    end

    // Final next state with enable abort and retry accounting, plus dwell counter reload.
    always_comb begin
        state_d = norm_next_s;
        retry_d = retry_q;
        if (abort_s) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
        end else if (retry_hit_s) begin
            retry_d = retry_inc_s;
            if ({28'd0, retry_inc_s} >= 32'(MAX_RETRIES)) state_d = ST_FAIL;
            else                                          state_d = ST_DCM_RST;
        end else if (state_q == ST_IDLE && enable) begin
            retry_d = 4'd0;
        end else begin
            retry_d = retry_q;
        end

        if (state_d != state_q) cnt_d = load_value(state_d);
        else if (expired_s)     cnt_d = cnt_q;
        else                    cnt_d = cnt_q - CW'(1);
    end

`ifdef QUADC_CTRL_STALL_DETECT_EN
    // Consecutive valid-low count while staying in RUN.
    always_comb begin
        stall_d = {SW{1'b0}};
        if (state_q == ST_RUN && state_d == ST_RUN && !adc_valid) stall_d = stall_q + SW'(1);
        else                                                      stall_d = {SW{1'b0}};
    end

    // Stall counter register.
    always_ff @(posedge user_clk or negedge rst_int_n) begin
        if (!rst_int_n) stall_q <= {SW{1'b0}};
        else            stall_q <= stall_d;
    end
`endif

    // State, counter, retry and decoded output registers.
    always_ff @(posedge user_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            retry_q     <= 4'd0;
            dcm_reset_q <= 1'b1;
            if_reset_q  <= 1'b1;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            dcm_reset_q <= (state_d == ST_IDLE) || (state_d == ST_DCM_RST) || (state_d == ST_FAIL);
            if_reset_q  <= !((state_d == ST_WAIT_VALID) || (state_d == ST_RUN));
            ready_q     <= (state_d == ST_RUN);
            error_q     <= (state_d == ST_FAIL);
        end
    end

    assign dcm_reset   = dcm_reset_q;
    assign if_reset    = if_reset_q;
    assign ready       = ready_q;
    assign error       = error_q;
    assign retry_count = retry_q;
    assign state       = state_q;
endmodule

// File: tb/tb_quadc_bringup_ctrl.sv
// Bench for quadc_bringup_ctrl: behavioural sequence model checked every cycle, plus directed literal checks.
module tb_quadc_bringup_ctrl;
    localparam int DCM_N = 16;
    localparam int LT_N  = 128;
    localparam int SET_N = 1024;
    localparam int IF_N  = 8;
    localparam int VT_N  = 256;
    localparam int ST_N  = 64;
    localparam int MAX_N = 3;

    logic user_clk = 1'b0;
    logic reset_n = 1'b0, enable = 1'b0, dcm_locked = 1'b0, adc_valid = 1'b0, clear_error = 1'b0;
    logic dcm_reset, if_reset, ready, error;
    logic [3:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    quadc_bringup_ctrl #(
        .DCM_RST_CYCLES(DCM_N), .LOCK_TIMEOUT(LT_N), .SETTLE_CYCLES(SET_N), .IF_RST_CYCLES(IF_N),
        .VALID_TIMEOUT(VT_N), .STALL_CYCLES(ST_N), .MAX_RETRIES(MAX_N)
    ) dut (
        .user_clk(user_clk), .reset_n(reset_n), .enable(enable), .dcm_locked(dcm_locked),
        .adc_valid(adc_valid), .clear_error(clear_error), .dcm_reset(dcm_reset), .if_reset(if_reset),
        .ready(ready), .error(error), .retry_count(retry_count), .state(state)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase number, cycles spent in phase, consecutive-low count, lock history.
    int m_state = 0, m_el = 0, m_gap = 0, m_retry = 0, m_hold = 2;
    bit m_lk1 = 1'b0, m_lk2 = 1'b0;

    always @(posedge user_clk or negedge reset_n) begin
        int ns, nr;
        bit fa;
        if (!reset_n) begin
            m_state <= 0; m_el <= 0; m_gap <= 0; m_retry <= 0; m_hold <= 2;
            m_lk1 <= 1'b0; m_lk2 <= 1'b0;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
        end else begin
            ns = m_state; nr = m_retry; fa = 1'b0;
            case (m_state)
                0: if (enable) begin ns = 1; nr = 0; end
                1: if (m_el == DCM_N - 1) ns = 2;
                2: if (m_lk2) ns = 3; else if (m_el == LT_N - 1) fa = 1'b1;
                3: if (!m_lk2) fa = 1'b1; else if (m_el == SET_N - 1) ns = 4;
                4: if (m_el == IF_N - 1) ns = 5;
                5: if (adc_valid) ns = 6; else if (m_el == VT_N - 1) fa = 1'b1;
                6: begin
                    if (!m_lk2) fa = 1'b1;
`ifdef QUADC_CTRL_STALL_DETECT_EN
                    if (!adc_valid && m_gap == ST_N - 1) fa = 1'b1;
`endif
                end
                7: if (clear_error) ns = 0;
                default: ns = 0;
            endcase
            if (fa) begin
                nr = (m_retry < 15) ? m_retry + 1 : 15;
                ns = (nr >= MAX_N) ? 7 : 1;
            end
            if (m_state != 7 && !enable) begin ns = 0; nr = m_retry; end
            m_el    <= (ns == m_state) ? m_el + 1 : 0;
            m_gap   <= (ns == 6 && m_state == 6 && !adc_valid) ? m_gap + 1 : 0;
            m_state <= ns;
            m_retry <= nr;
            m_lk1   <= dcm_locked;
            m_lk2   <= m_lk1;
        end
    end

    logic [10:0] exp_v;
    always @(posedge user_clk) begin
        #1;
        exp_v[10:8] = 3'(m_state);
        exp_v[7:4]  = 4'(m_retry);
        exp_v[3]    = (m_state == 0 || m_state == 1 || m_state == 7);
        exp_v[2]    = !(m_state == 5 || m_state == 6);
        exp_v[1]    = (m_state == 6);
        exp_v[0]    = (m_state == 7);
        chk("cycle", {21'd0, state, retry_count, dcm_reset, if_reset, ready, error}, {21'd0, exp_v});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge user_clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k = 0;
        while (state !== s && k < budget) begin tick(1); k++; end
        chk(name, {29'd0, state}, {29'd0, s});
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 100000) begin tick(1); n++; end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {29'd0, state}, 32'd0);
        chk({tag, "_dcm"}, {31'd0, dcm_reset}, 32'd1);
        chk({tag, "_ifr"}, {31'd0, if_reset}, 32'd1);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_retry"}, {28'd0, retry_count}, 32'd0);
    endtask

    initial begin
        int n, k, pulses;
        logic [2:0] prev;

        tick(3);
        chk_reset_vals("por");
        reset_n = 1'b1;
        tick(5);

        // Nominal bring-up.
        enable = 1'b1;
        wait_state(3'd1, 4, "enter_dcm_rst");
        count_state(3'd1, n);
        chk("dcm_pulse_len", n, DCM_N);
        tick(100);
        dcm_locked = 1'b1;
        n = 0;
        while (if_reset === 1'b1 && n < 3000) begin tick(1); n++; end
        chk("ifrst_fall_after_lock", n, 3 + SET_N + IF_N);
        tick(10);
        adc_valid = 1'b1;
        tick(1);
        chk("nominal_ready", {31'd0, ready}, 32'd1);
        chk("nominal_retry", {28'd0, retry_count}, 32'd0);
        chk("model_in_run", m_state, 6);

        // One-cycle lock loss in RUN.
        dcm_locked = 1'b0;
        tick(1);
        dcm_locked = 1'b1;
        n = 1;
        while (ready === 1'b1 && n < 10) begin tick(1); n++; end
        chk("lockloss_latency", n, 3);
        chk("lockloss_retry", {28'd0, retry_count}, 32'd1);
        count_state(3'd1, n);
        chk("lockloss_dcm_len", n, DCM_N);
        wait_state(3'd6, 1200, "lockloss_recover");
        chk("lockloss_retry_kept", {28'd0, retry_count}, 32'd1);

        // Stall watchdog: 63-cycle gap tolerated, 64-cycle gap trips when built.
        for (int i = 0; i < 63; i++) begin adc_valid = 1'b0; tick(1); end
        adc_valid = 1'b1;
        tick(1);
        chk("stall_gap63_run", {29'd0, state}, 32'd6);
        for (int i = 0; i < 64; i++) begin adc_valid = 1'b0; tick(1); end
`ifdef QUADC_CTRL_STALL_DETECT_EN
        chk("stall_gap64_state", {29'd0, state}, 32'd1);
        chk("stall_gap64_retry", {28'd0, retry_count}, 32'd2);
`else
        chk("stall_gap64_state", {29'd0, state}, 32'd6);
        chk("stall_gap64_retry", {28'd0, retry_count}, 32'd1);
`endif
        adc_valid = 1'b1;
        wait_state(3'd6, 1200, "stall_recover");

        // Enable abort from RUN, then during SETTLE.
        enable = 1'b0;
        tick(1);
        chk("abort_run_state", {29'd0, state}, 32'd0);
        enable = 1'b1;
        wait_state(3'd1, 4, "reenter_dcm_rst");
        chk("retry_cleared", {28'd0, retry_count}, 32'd0);
        wait_state(3'd3, 100, "reach_settle");
        tick(5);
        enable = 1'b0;
        tick(1);
        chk("abort_settle_state", {29'd0, state}, 32'd0);
        chk("abort_settle_dcm", {31'd0, dcm_reset}, 32'd1);
        chk("abort_settle_ifr", {31'd0, if_reset}, 32'd1);

        // Enable drops on the cycle the third VALID_TIMEOUT would reach MAX_RETRIES.
        adc_valid = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!(state === 3'd5 && retry_count === 4'd2) && k < 5000) begin tick(1); k++; end
        chk("vt_third_attempt", {28'd0, retry_count}, 32'd2);
        tick(VT_N - 1);
        chk("vt_last_cycle_state", {29'd0, state}, 32'd5);
        enable = 1'b0;
        tick(1);
        chk("vt_abort_state", {29'd0, state}, 32'd0);
        chk("vt_abort_retry", {28'd0, retry_count}, 32'd2);
        chk("vt_abort_dcm", {31'd0, dcm_reset}, 32'd1);
        chk("vt_abort_ifr", {31'd0, if_reset}, 32'd1);

        // Lock timeout path to FAIL and clear_error.
        dcm_locked = 1'b0;
        tick(3);
        enable = 1'b1;
        k = 0; pulses = 0; prev = 3'd0;
        while (state !== 3'd7 && k < 2000) begin
            if (state === 3'd1 && prev !== 3'd1) pulses++;
            prev = state;
            tick(1);
            k++;
        end
        chk("lt_dcm_pulses", pulses, 3);
        chk("lt_state_fail", {29'd0, state}, 32'd7);
        chk("lt_error", {31'd0, error}, 32'd1);
        chk("lt_retry", {28'd0, retry_count}, 32'd3);
        tick(5);
        chk("fail_holds_with_enable", {29'd0, state}, 32'd7);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        chk("clear_to_idle", {29'd0, state}, 32'd0);
        chk("clear_error_low", {31'd0, error}, 32'd0);
        tick(1);
        chk("idle_resamples_enable", {29'd0, state}, 32'd1);

        // Asynchronous reset in WAIT_VALID.
        dcm_locked = 1'b1;
        wait_state(3'd5, 1500, "reach_wait_valid");
        tick(10);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        enable = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("post_reset_idle", {29'd0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
